// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit multiplexed seven-segment display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry n is {CA..CG} for hex digit n; a 0 lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {BLANK, DRIVE} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
    } frame_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low {CA..CG} segment pattern.
// Latency: combinational. Backpressure: none.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a double-buffered 8-digit hex frame onto shared cathodes/anodes with a blank gap per digit.
// Latency: outputs registered, a committed frame shows from the next frame boundary onward.
// Backpressure: frame_ready low while the pending buffer holds an uncommitted frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] frame_data,
    input  logic [7:0]  frame_dp,
    input  logic [7:0]  frame_en,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        frame_done,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN
);

    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGIT_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   digit_cnt_q, digit_cnt_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic [2:0]      idx_q, idx_d;
    frame_t          pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    frame_t          shadow_q, shadow_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            done_q, done_d;
    logic            boundary;
    logic            accept;
    logic [6:0]      dec_seg;

    // Decode the digit about to be shown, so segments register together with the anode.
    seg7_hex_decoder u_dec (
        .nibble (shadow_q.data[{idx_d, 2'b00} +: 4]),
        .seg    (dec_seg)
    );

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        blank_cnt_d = blank_cnt_q;
        idx_d       = idx_q;
        boundary    = 1'b0;
        case (state_q)
            BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = DRIVE;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            DRIVE: begin
                if (digit_cnt_q == DIGIT_LAST) begin
                    state_d     = BLANK;
                    digit_cnt_d = '0;
                    idx_d       = idx_q + 3'd1;
                    boundary    = (idx_q == 3'd7);
                end else begin
                    digit_cnt_d = digit_cnt_q + DW'(1);
                end
            end
            default: state_d = BLANK;
        endcase
    end

    assign frame_ready = !pend_full_q;
    assign accept      = frame_valid && frame_ready;

    // A boundary commit and an accept never coincide: accept needs the pending buffer empty.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        if (boundary && pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d      = '{data: frame_data, dp: frame_dp, en: frame_en};
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        done_d = boundary;
        if (state_d == DRIVE && shadow_q.en[idx_d]) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = dec_seg;
            dp_d  = ~shadow_q.dp[idx_d];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= BLANK;
            digit_cnt_q <= '0;
            blank_cnt_q <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            shadow_q    <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            shadow_q    <= shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            done_q      <= done_d;
        end
    end

    assign AN         = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP         = dp_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Random and directed stimulus against a frame/slot-timing model of the display scan.
module tb_seg7_scan_driver;

    localparam int DIG = 4;
    localparam int BLK = 2;
    localparam int SLOT = DIG + BLK;
    localparam int FRAME = 8 * SLOT;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [31:0] frame_data = '0;
    logic [7:0]  frame_dp = '0;
    logic [7:0]  frame_en = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready, frame_done;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0]  AN;
    logic [6:0]  seg;

    assign seg = {CA, CB, CC, CD, CE, CF, CG};

    seg7_scan_driver #(.DIGIT_CYCLES(DIG), .BLANK_CYCLES(BLK)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .frame_data(frame_data), .frame_dp(frame_dp), .frame_en(frame_en),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_done(frame_done),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
        .DP(DP), .AN(AN)
    );

    always #5 sys_clk = ~sys_clk;

    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: cycles since reset release, plus one pending slot and the displayed frame.
    int          cyc = 0;
    bit          m_full = 1'b0;
    logic [31:0] m_p_data = '0, m_s_data = '0;
    logic [7:0]  m_p_dp = '0, m_p_en = '0, m_s_dp = '0, m_s_en = '0;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cyc = 0; m_full = 1'b0;
            m_p_data = '0; m_p_dp = '0; m_p_en = '0;
            m_s_data = '0; m_s_dp = '0; m_s_en = '0;
        end else begin
            bit acc;
            acc = frame_valid && !m_full;
            cyc++;
            if (cyc % FRAME == 0 && m_full) begin
                m_s_data = m_p_data; m_s_dp = m_p_dp; m_s_en = m_p_en;
                m_full = 1'b0;
            end else if (acc) begin
                m_p_data = frame_data; m_p_dp = frame_dp; m_p_en = frame_en;
                m_full = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            int p, slot;
            logic [7:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            logic [3:0] nib;
            p = cyc % FRAME;
            slot = p / SLOT;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            if ((p % SLOT) >= BLK && m_s_en[slot]) begin
                nib = 4'(m_s_data >> (4 * slot));
                e_an = ~(8'd1 << slot);
                e_seg = seg_ref[nib];
                e_dp = ~m_s_dp[slot];
            end
            check("model_AN", AN, e_an);
            check("model_seg", seg, e_seg);
            check("model_DP", DP, e_dp);
            check("model_done", frame_done, (cyc > 0 && p == 0));
            check("model_ready", frame_ready, !m_full);
        end
    end

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc != t && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        if (cyc != t) begin
            n_chk++; n_fail++;
            $display("FAIL wait_cyc: reached %0d, wanted %0d", cyc, t);
        end
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        frame_data = d; frame_dp = dp; frame_en = en; frame_valid = 1'b1;
    endtask

    task automatic check_off(input string name);
        check({name, "_AN"}, AN, 8'hFF);
        check({name, "_seg"}, seg, 7'h7F);
        check({name, "_DP"}, DP, 1'b1);
        check({name, "_ready"}, frame_ready, 1'b1);
        check({name, "_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int dark, bad, f;
        #2 sys_rst = 1'b1;
        #1 check_off("rst_async");
        chk_en = 1'b1;
        @(negedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0;

        dark = 0;
        repeat (FRAME) begin
            @(negedge sys_clk);
            if (AN != 8'hFF) dark++;
        end
        check("dark_after_reset", dark, 0);
        check("empty_boundary_done", frame_done, 1'b1);

        // Digit scan
        offer(32'h76543210, 8'h01, 8'hFF);
        @(negedge sys_clk);
        frame_valid = 1'b0;
        check("scan_ready_low", frame_ready, 1'b0);
        wait_cyc(96);
        check("scan_done", frame_done, 1'b1);
        wait_cyc(97);
        check("scan_blank_AN", AN, 8'hFF);
        wait_cyc(98);
        check("dig0_AN", AN, 8'hFE);
        check("dig0_seg", seg, 7'b0000001);
        check("dig0_DP", DP, 1'b0);
        wait_cyc(140);
        check("dig7_AN", AN, 8'h7F);
        check("dig7_seg", seg, 7'b0001111);
        check("dig7_DP", DP, 1'b1);

        // Back-pressure: A then B
        wait_cyc(150);
        offer(32'h000000A5, 8'h00, 8'hFF);
        @(negedge sys_clk);
        check("bp_A_held", frame_ready, 1'b0);
        offer(32'h0000000B, 8'h00, 8'hFF);
        wait_cyc(192);
        check("bp_commit_ready", frame_ready, 1'b1);
        check("bp_commit_done", frame_done, 1'b1);
        @(negedge sys_clk);
        frame_valid = 1'b0;
        check("bp_B_accepted", frame_ready, 1'b0);
        wait_cyc(194);
        check("bp_A_seg", seg, 7'b0100100);
        wait_cyc(242);
        check("bp_B_seg", seg, 7'b1100000);

        // Enable mask
        offer(32'h89ABCDEF, 8'h00, 8'hAA);
        @(negedge sys_clk);
        frame_valid = 1'b0;
        wait_cyc(288);
        bad = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            if (AN == 8'hFE || AN == 8'hFB || AN == 8'hEF || AN == 8'hBF) bad++;
            if (i == 8) begin
                check("mask_dig1_AN", AN, 8'hFD);
                check("mask_dig1_seg", seg, 7'b0110000);
            end
            @(negedge sys_clk);
        end
        check("mask_forbidden", bad, 0);

        // Valid rising exactly on a boundary with pending empty
        offer(32'h00000003, 8'h00, 8'hFF);
        @(negedge sys_clk);
        frame_valid = 1'b0;
        check("sim_ready", frame_ready, 1'b0);
        check("sim_done", frame_done, 1'b1);
        wait_cyc(344);
        check("sim_shadow_kept", AN, 8'hFD);
        wait_cyc(386);
        check("sim_commit_AN", AN, 8'hFE);
        check("sim_commit_seg", seg, 7'b0000110);

        // Random traffic
        repeat (2000) begin
            @(negedge sys_clk);
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_data = $urandom;
            frame_dp = 8'($urandom);
            frame_en = 8'($urandom);
        end
        frame_valid = 1'b0;

        // Reset in DRIVE of digit 3 with a frame pending
        f = (cyc / FRAME + 1) * FRAME;
        wait_cyc(f + 1);
        offer(32'h12345678, 8'hFF, 8'hFF);
        @(negedge sys_clk);
        frame_valid = 1'b0;
        check("mid_pending", frame_ready, 1'b0);
        wait_cyc(f + 3 * SLOT + BLK + 1);
        #2 sys_rst = 1'b1;
        #1 check_off("rst_mid");
        @(negedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0;
        dark = 0;
        repeat (2 * FRAME) begin
            @(negedge sys_clk);
            if (AN != 8'hFF) dark++;
        end
        check("mid_pending_discarded", dark, 0);

        @(negedge sys_clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
